// File: rtl/seq_muldiv_unit_pkg.sv
// ----------------------------------------------------------------------------
// seq_muldiv_unit_pkg
//   Shared types and constants for the iterative multiply/divide unit.
//   - state_t : 2-bit FSM state encoding (also exported on the debug port)
//   - op_t    : latched operation (multiply or divide)
//   - DEFAULT_BITS : default operand width
//   - op_select_valid() : an op request is well formed when exactly one of
//     MUL/DIV is set
// ----------------------------------------------------------------------------
package seq_muldiv_unit_pkg;

  localparam int DEFAULT_BITS = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

  function automatic logic op_select_valid(input logic mul, input logic div);
    return mul ^ div;
  endfunction

endpackage : seq_muldiv_unit_pkg

// File: rtl/seq_muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// seq_muldiv_unit_if
//   Control-unit <-> multiply/divide unit bundle.
//   master (control unit): drives start, MUL, DIV, A, B
//   slave  (mul/div unit): drives HIVal, LOVal, busy, done, div_by_zero,
//                          dbg_state
//
//   Handshake: a request is a cycle with start=1 and exactly one of MUL/DIV
//   set; the unit takes it on the rising edge only while it is not busy
//   (IDLE or DONE). A, B and the op are captured on that edge, so the master
//   may change them afterwards. busy stays high while the op iterates, and
//   done pulses for exactly one cycle when HIVal/LOVal carry the new result.
//   A request seen while busy is dropped, not queued; the master retries.
// ----------------------------------------------------------------------------
interface seq_muldiv_unit_if
  import seq_muldiv_unit_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
);

  logic            start;
  logic            MUL;
  logic            DIV;
  logic [BITS-1:0] A;
  logic [BITS-1:0] B;
  logic [BITS-1:0] HIVal;
  logic [BITS-1:0] LOVal;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  state_t          dbg_state;

  modport master (
    output start, MUL, DIV, A, B,
    input  HIVal, LOVal, busy, done, div_by_zero, dbg_state
  );

  modport slave (
    input  start, MUL, DIV, A, B,
    output HIVal, LOVal, busy, done, div_by_zero, dbg_state
  );

endinterface : seq_muldiv_unit_if

// File: rtl/seq_muldiv_unit_muldiv_step.sv
// ----------------------------------------------------------------------------
// muldiv_step
//   Combinational single iteration of the multiply/divide datapath.
//   Inputs : i_op  - OP_MUL / OP_DIV
//            i_acc - accumulator (mul) / partial remainder (div), BITS+1 wide
//            i_m   - multiplicand (sign/zero extended) / divisor magnitude
//            i_q   - multiplier (mul) / dividend-quotient shift register (div)
//            i_qm1 - Booth q(-1) bit (mul only)
//   Outputs: o_acc, o_q, o_qm1 - register values after this iteration
//
//   MUL, SIGNED=1 : Booth radix-2 add/sub on {acc,Q,q-1} then arithmetic
//                   right shift. acc carries one guard bit so +/-min never
//                   overflows the partial sum.
//   MUL, SIGNED=0 : shift-add; the guard bit holds the carry-out.
//   DIV           : restoring step on magnitudes: shift {rem,Q} left, try
//                   rem - divisor, keep it when non-negative, quotient bit
//                   enters at Q[0].
// ----------------------------------------------------------------------------
module muldiv_step
  import seq_muldiv_unit_pkg::*;
#(
  parameter int BITS   = DEFAULT_BITS,
  parameter bit SIGNED = 1'b1
) (
  input  op_t             i_op,
  input  logic [BITS:0]   i_acc,
  input  logic [BITS:0]   i_m,
  input  logic [BITS-1:0] i_q,
  input  logic            i_qm1,
  output logic [BITS:0]   o_acc,
  output logic [BITS-1:0] o_q,
  output logic            o_qm1
);

  logic [BITS:0] w_sum;
  logic [BITS:0] w_rem_sh;
  logic [BITS:0] w_diff;

  always_comb begin
    w_sum    = i_acc;
    w_rem_sh = {i_acc[BITS-1:0], i_q[BITS-1]};
    w_diff   = w_rem_sh - i_m;
    o_acc    = i_acc;
    o_q      = i_q;
    o_qm1    = i_qm1;

    if (i_op == OP_MUL) begin
      if (SIGNED) begin
        case ({i_q[0], i_qm1})
          2'b01:   w_sum = i_acc + i_m;
          2'b10:   w_sum = i_acc - i_m;
          default: w_sum = i_acc;
        endcase
        o_acc = {w_sum[BITS], w_sum[BITS:1]};
      end else begin
        w_sum = i_q[0] ? (i_acc + i_m) : i_acc;
        o_acc = {1'b0, w_sum[BITS:1]};
      end
      // Bit shifted out of the accumulator becomes the new Q MSB.
      o_q   = {w_sum[0], i_q[BITS-1:1]};
      o_qm1 = i_q[0];
    end else begin
      // Shifted remainder is always < 2*divisor, so the top bit of the
      // difference is a reliable "went negative" flag.
      if (!w_diff[BITS]) begin
        o_acc = w_diff;
        o_q   = {i_q[BITS-2:0], 1'b1};
      end else begin
        o_acc = w_rem_sh;
        o_q   = {i_q[BITS-2:0], 1'b0};
      end
      o_qm1 = 1'b0;
    end
  end

endmodule : muldiv_step

// File: rtl/seq_muldiv_unit.sv
// ----------------------------------------------------------------------------
// seq_muldiv_unit
//   Iterative multiply/divide unit. A (from RY) and B (from the bus) are
//   captured on an accepted start; BITS iterations later a one-cycle FIXUP
//   applies signs for signed divide, and the 2*BITS result is loaded into
//   HIVal/LOVal together with a one-cycle done pulse.
//
//   Ports:
//     Clock  - system clock, rising edge
//     reset  - asynchronous, active-high
//     bus    - seq_muldiv_unit_if.slave:
//                start/MUL/DIV/A/B in, HIVal/LOVal/busy/done/div_by_zero out,
//                dbg_state = current FSM state
//
//   Results:  MUL -> HIVal = product[2B-1:B], LOVal = product[B-1:0]
//             DIV -> HIVal = remainder (sign of A), LOVal = quotient
//                    (truncated toward zero)
//             DIV by zero -> HIVal = A, LOVal = all ones, div_by_zero = 1,
//                    done the cycle after the request edge
//   Latency:  done is high in the cycle after edge E0+BITS+1.
// ----------------------------------------------------------------------------
module seq_muldiv_unit
  import seq_muldiv_unit_pkg::*;
#(
  parameter  int BITS   = DEFAULT_BITS,
  parameter  bit SIGNED = 1'b1,
  localparam int CNTW   = $clog2(BITS + 1)
) (
  input  logic             Clock,
  input  logic             reset,
  seq_muldiv_unit_if.slave bus
);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t          r_state;
  state_t          w_next_state;
  logic [CNTW-1:0] r_cnt;
  op_t             r_op;
  logic [BITS:0]   r_acc;
  logic [BITS:0]   r_m;
  logic [BITS-1:0] r_q;
  logic            r_qm1;
  logic            r_a_neg;
  logic            r_b_neg;
  logic [BITS-1:0] r_hi;
  logic [BITS-1:0] r_lo;
  logic            r_done;
  logic            r_dbz;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic            w_can_accept;
  logic            w_accept;
  logic            w_div_zero;
  logic            w_last_iter;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [BITS-1:0] w_a_mag;
  logic [BITS-1:0] w_b_mag;

  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept     = bus.start && op_select_valid(bus.MUL, bus.DIV) && w_can_accept;
  assign w_div_zero   = w_accept && bus.DIV && (bus.B == '0);
  assign w_last_iter  = (r_state == S_ITER) && (r_cnt == CNTW'(BITS - 1));

  // Divide works on magnitudes; signs are reapplied in FIXUP.
  assign w_a_neg = SIGNED && bus.A[BITS-1];
  assign w_b_neg = SIGNED && bus.B[BITS-1];
  assign w_a_mag = w_a_neg ? -bus.A : bus.A;
  assign w_b_mag = w_b_neg ? -bus.B : bus.B;

  // --------------------------------------------------------------------------
  // FSM process 1: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        // Divide by zero skips the iterations and finishes on the accept edge.
        if (w_accept) begin
          w_next_state = w_div_zero ? S_DONE : S_ITER;
        end
      end
      S_ITER: begin
        if (w_last_iter) begin
          w_next_state = S_FIXUP;
        end
      end
      S_FIXUP: begin
        w_next_state = S_DONE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM process 3: control outputs
  // --------------------------------------------------------------------------
  logic w_busy;
  logic w_load_operands;
  logic w_step_en;
  logic w_load_result;

  always_comb begin
    w_busy          = 1'b0;
    w_load_operands = 1'b0;
    w_step_en       = 1'b0;
    w_load_result   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_load_operands = w_accept && !w_div_zero;
      end
      S_ITER: begin
        w_busy    = 1'b1;
        w_step_en = 1'b1;
      end
      S_FIXUP: begin
        w_busy        = 1'b1;
        w_load_result = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // One iteration of the datapath
  // --------------------------------------------------------------------------
  logic [BITS:0]   w_acc_n;
  logic [BITS-1:0] w_q_n;
  logic            w_qm1_n;

  muldiv_step #(
    .BITS   (BITS),
    .SIGNED (SIGNED)
  ) u_step (
    .i_op  (r_op),
    .i_acc (r_acc),
    .i_m   (r_m),
    .i_q   (r_q),
    .i_qm1 (r_qm1),
    .o_acc (w_acc_n),
    .o_q   (w_q_n),
    .o_qm1 (w_qm1_n)
  );

  // --------------------------------------------------------------------------
  // Operand / iteration registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_op    <= OP_MUL;
      r_acc   <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_a_neg <= 1'b0;
      r_b_neg <= 1'b0;
    end else if (w_load_operands) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_qm1   <= 1'b0;
      r_a_neg <= w_a_neg;
      r_b_neg <= w_b_neg;
      if (bus.MUL) begin
        // Booth: A is the multiplicand added/subtracted, B is scanned in Q.
        r_op <= OP_MUL;
        r_m  <= {w_a_neg, bus.A};
        r_q  <= bus.B;
      end else begin
        r_op <= OP_DIV;
        r_m  <= {1'b0, w_b_mag};
        r_q  <= w_a_mag;
      end
    end else if (w_step_en) begin
      r_acc <= w_acc_n;
      r_q   <= w_q_n;
      r_qm1 <= w_qm1_n;
      r_cnt <= w_last_iter ? '0 : r_cnt + CNTW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Result fixup (evaluated during FIXUP, loaded on the DONE edge)
  // --------------------------------------------------------------------------
  logic [BITS-1:0] w_res_hi;
  logic [BITS-1:0] w_res_lo;

  always_comb begin
    w_res_hi = r_acc[BITS-1:0];
    w_res_lo = r_q;
    if (SIGNED && (r_op == OP_DIV)) begin
      // min / -1 lands here too: magnitude 2^(BITS-1) negated is min again.
      if (r_a_neg ^ r_b_neg) begin
        w_res_lo = -r_q;
      end
      if (r_a_neg) begin
        w_res_hi = -r_acc[BITS-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result / status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load_result) begin
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
        r_done <= 1'b1;
      end
      if (w_accept) begin
        r_dbz <= w_div_zero;
      end
      if (w_div_zero) begin
        r_hi   <= bus.A;
        r_lo   <= '1;
        r_done <= 1'b1;
      end
    end
  end

  assign bus.HIVal       = r_hi;
  assign bus.LOVal       = r_lo;
  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.dbg_state   = r_state;

endmodule : seq_muldiv_unit

// File: tb/tb_seq_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_seq_muldiv_unit
//   Directed and randomized bench for seq_muldiv_unit (BITS=32, SIGNED=1).
//   Expected results come from 64-bit signed integer arithmetic.
// ----------------------------------------------------------------------------
module tb_seq_muldiv_unit;

  localparam int BITS = 32;
  localparam int W    = 65;   // {div_by_zero, HIVal, LOVal}

  logic Clock;
  logic reset;

  seq_muldiv_unit_if #(.BITS(BITS)) bus ();

  seq_muldiv_unit #(
    .BITS   (BITS),
    .SIGNED (1'b1)
  ) dut (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus)
  );

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [63:0]  last_res = '0;
  logic         last_dbz = 1'b0;
  int           cur_lat  = 0;

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic logic [W-1:0] model(input bit is_mul, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mul) begin
      p = sa * sb;
      return {1'b0, p[63:0]};
    end
    if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Driver tasks (entered just after a falling edge)
  // --------------------------------------------------------------------------
  task automatic launch(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(model(is_mul, a, b));
    cur_lat   = (is_mul || b != 32'h0) ? BITS + 1 : 0;
    bus.start = 1'b1;
    bus.MUL   = is_mul;
    bus.DIV   = !is_mul;
    bus.A     = a;
    bus.B     = b;
    @(negedge Clock);
    bus.start = 1'b0;
    bus.MUL   = 1'b0;
    bus.DIV   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat_start);
    int           lat;
    logic [W-1:0] exp;
    lat = lat_start;
    if (lat_start == 0 && cur_lat > 0)
      check({tag, "/accept"}, {bus.busy, bus.done, bus.div_by_zero}, 3'b100);
    while (bus.done !== 1'b1 && lat < 100) begin
      if (cur_lat > 1 && lat == cur_lat - 2)
        check({tag, "/hold"}, {bus.HIVal, bus.LOVal}, last_res);
      @(negedge Clock);
      lat++;
    end
    check({tag, "/latency"}, lat, cur_lat);
    check({tag, "/sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check({tag, "/result"}, {bus.div_by_zero, bus.HIVal, bus.LOVal}, exp);
      check({tag, "/busy_low"}, bus.busy, 0);
      last_res = exp[63:0];
      last_dbz = exp[64];
    end
  endtask

  task automatic settle(input string tag);
    @(negedge Clock);
    check({tag, "/pulse"}, {bus.busy, bus.done}, 2'b00);
    check({tag, "/held"}, {bus.div_by_zero, bus.HIVal, bus.LOVal}, {last_dbz, last_res});
  endtask

  task automatic ignore_start(input string tag, input logic mul, input logic div);
    bus.start = 1'b1;
    bus.MUL   = mul;
    bus.DIV   = div;
    bus.A     = $urandom;
    bus.B     = 32'h0;
    @(negedge Clock);
    bus.start = 1'b0;
    bus.MUL   = 1'b0;
    bus.DIV   = 1'b0;
    check(tag, {bus.busy, bus.done, bus.div_by_zero, bus.HIVal, bus.LOVal},
          {2'b00, last_dbz, last_res});
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence, then random traffic
  // --------------------------------------------------------------------------
  initial begin
    bus.start = 1'b0;
    bus.MUL   = 1'b0;
    bus.DIV   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    reset     = 1'b0;
    #1;
    // Reset held with a request pending: nothing may start.
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.MUL   = 1'b1;
    bus.A     = $urandom;
    bus.B     = $urandom;
    repeat (4) begin
      @(negedge Clock);
      check("reset_hold", {bus.busy, bus.done, bus.div_by_zero, bus.HIVal, bus.LOVal}, 0);
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.MUL   = 1'b0;
    @(negedge Clock);
    check("after_reset", {bus.busy, bus.done, bus.HIVal, bus.LOVal}, 0);

    launch(1'b1, 32'd7, 32'hFFFF_FFFD);
    wait_done("mul_7_x_m3", 0);
    settle("mul_7_x_m3");

    launch(1'b1, 32'h8000_0000, 32'h8000_0000);
    wait_done("mul_min_x_min", 0);
    settle("mul_min_x_min");

    launch(1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_by_2", 0);
    settle("div_m7_by_2");

    launch(1'b0, 32'd5, 32'd0);
    wait_done("div_5_by_0", 0);
    settle("div_5_by_0");

    // Malformed requests in DONE are ignored; the sticky flag survives them.
    ignore_start("ignore_mul_and_div", 1'b1, 1'b1);
    ignore_start("ignore_no_op", 1'b0, 1'b0);

    // Request mid-iteration is dropped; in-flight multiply completes intact.
    launch(1'b1, 32'h1234_5678, 32'hFEDC_BA98);
    repeat (10) @(negedge Clock);
    bus.start = 1'b1;
    bus.DIV   = 1'b1;
    bus.A     = 32'd5;
    bus.B     = 32'd0;
    @(negedge Clock);
    bus.start = 1'b0;
    bus.DIV   = 1'b0;
    wait_done("mul_with_midstart", 11);
    settle("mul_with_midstart");

    launch(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_min_by_m1", 0);

    // Back-to-back: next request in the done cycle.
    launch(1'b0, 32'd100, 32'hFFFF_FFF9);
    wait_done("div_b2b", 0);
    settle("div_b2b");

    // Reset in the middle of a multiply aborts it with no partial result.
    launch(1'b1, 32'd3, 32'd4);
    repeat (10) @(negedge Clock);
    reset = 1'b1;
    #1;
    check("reset_midop", {bus.busy, bus.done, bus.div_by_zero, bus.HIVal, bus.LOVal}, 0);
    @(negedge Clock);
    reset = 1'b0;
    exp_q.delete();
    last_res = '0;
    last_dbz = 1'b0;
    @(negedge Clock);
    check("reset_midop_idle", {bus.busy, bus.done, bus.HIVal, bus.LOVal}, 0);
    launch(1'b1, 32'd3, 32'd4);
    wait_done("mul_3x4_after_reset", 0);
    settle("mul_3x4_after_reset");

    for (int i = 0; i < 30; i++) begin
      launch(1'($urandom_range(0, 1)), pick(), pick());
      wait_done($sformatf("rand_%0d", i), 0);
      if ($urandom_range(0, 1) == 1) settle($sformatf("rand_%0d", i));
    end
    settle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seq_muldiv_unit
